serial_cmp_nb: RTL

Parametrised, bit-serial magnitude comparator for two WIDTH-bit operands, with a start/busy/done handshake.
- Scans the operands MSB-first, one bit per clock, and stops early at the first differing bit.
- Registers lt/eq/gt flags plus a mode-selected boolean result.
- Supports unsigned or two's-complement operands, selected per operation.
- Generalises the team's fixed 2-bit "less-than" gate network into a reusable sequential block for the datapath.

---
 rtl/serial_cmp_nb_if.sv | 27 ++
 rtl/serial_cmp_nb.sv | 111 +++++++++++
 2 files changed

// File: rtl/serial_cmp_nb_if.sv
// Request/response bundle for the bit-serial magnitude comparator.
// The requester drives start and the operands. The comparator drives the status and flag outputs.
interface serial_cmp_nb_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic [1:0]       mode;
    logic             busy;
    logic             done;
    logic             lt;
    logic             eq;
    logic             gt;
    logic             result;

    modport master (
        output start, a, b, is_signed, mode,
        input  busy, done, lt, eq, gt, result
    );

    modport slave (
        input  start, a, b, is_signed, mode,
        output busy, done, lt, eq, gt, result
    );
endinterface

// File: rtl/serial_cmp_nb.sv
// Bit-serial MSB-first magnitude comparator, unsigned or two's-complement.
// It stops at the first differing bit and registers lt/eq/gt plus a mode-selected result.
module serial_cmp_nb #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_cmp_nb_if.slave  bus
);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] ra_q;
    logic [WIDTH-1:0] rb_q;
    logic             is_signed_q;
    logic [1:0]       mode_q;
    logic [IDX_W-1:0] idx_q;
    logic             busy_q;
    logic             done_q;
    logic             lt_q;
    logic             eq_q;
    logic             gt_q;
    logic             result_q;

    logic bit_a;
    logic bit_b;
    logic at_msb;
    logic at_lsb;
    logic differ;
    logic a_wins;
    logic lt_d;
    logic eq_d;
    logic gt_d;
    logic result_d;

    always_comb begin
        bit_a  = ra_q[idx_q];
        bit_b  = rb_q[idx_q];
        at_msb = (idx_q == IDX_W'(WIDTH - 1));
        at_lsb = (idx_q == '0);
        differ = bit_a ^ bit_b;
        // A signed sign bit of 1 means a smaller value, so the sense inverts there.
        a_wins = bit_a ^ (is_signed_q & at_msb);
        lt_d   = differ & ~a_wins;
        gt_d   = differ & a_wins;
        eq_d   = ~differ;
        result_d = 1'b0;
        unique case (mode_q)
            2'b00: result_d = lt_d;
            2'b01: result_d = eq_d;
            2'b10: result_d = gt_d;
            2'b11: result_d = lt_d | eq_d;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ra_q        <= '0;
            rb_q        <= '0;
            is_signed_q <= 1'b0;
            mode_q      <= 2'b00;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            result_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        ra_q        <= bus.a;
                        rb_q        <= bus.b;
                        is_signed_q <= bus.is_signed;
                        mode_q      <= bus.mode;
                        idx_q       <= IDX_W'(WIDTH - 1);
                        busy_q      <= 1'b1;
                        state_q     <= StScan;
                    end
                end
                StScan: begin
                    if (differ || at_lsb) begin
                        lt_q     <= lt_d;
                        eq_q     <= eq_d;
                        gt_q     <= gt_d;
                        result_q <= result_d;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= StIdle;
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.lt     = lt_q;
    assign bus.eq     = eq_q;
    assign bus.gt     = gt_q;
    assign bus.result = result_q;

endmodule
